// File: rtl/mult_arbiter_if.sv
// Bus between the two requesters, the shared external 8x8 multiplier and the
// display, bundled for the mult_arbiter.
interface mult_arbiter_if;
    logic [1:0]  req;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic [1:0]  done;
    logic [15:0] product0;
    logic [15:0] product1;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic [15:0] mult_c;
    logic        busy;
    logic [15:0] disp_product;
    logic        disp_src;

    modport slave (
        input  req, a0, b0, a1, b1, mult_c,
        output done, product0, product1, mult_a, mult_b, busy, disp_product, disp_src
    );

    modport master (
        output req, a0, b0, a1, b1, mult_c,
        input  done, product0, product1, mult_a, mult_b, busy, disp_product, disp_src
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external combinational 8x8 multiplier
// between two requesters; product captured WAIT_CYCLES after the grant.
module mult_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned INVERT_A    = 1
) (
    input logic           clk,
    input logic           rst_n,
    mult_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             prio;
    logic             owner;
    logic             grant_c;
    logic             grant_idx_c;
    logic             capture_c;
    logic [7:0]       a_sel_c;
    logic [7:0]       b_sel_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|bus.req) state_next = WAIT;
            WAIT:    if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant/capture decode and operand selection; prio names the favoured requester
    always_comb begin
        grant_c     = (state == IDLE) && (|bus.req);
        grant_idx_c = (bus.req == 2'b11) ? prio : bus.req[1];
        capture_c   = (state == WAIT) && (cnt == CNT_LAST);
        a_sel_c     = grant_idx_c ? bus.a1 : bus.a0;
        b_sel_c     = grant_idx_c ? bus.b1 : bus.b0;
        if (INVERT_A != 0) a_sel_c = ~a_sel_c;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            prio             <= 1'b0;
            owner            <= 1'b0;
            bus.done         <= '0;
            bus.busy         <= 1'b0;
            bus.mult_a       <= '0;
            bus.mult_b       <= '0;
            bus.product0     <= '0;
            bus.product1     <= '0;
            bus.disp_product <= '0;
            bus.disp_src     <= 1'b0;
        end else begin
            bus.busy <= (state_next != IDLE);
            bus.done <= '0;
            if (grant_c) begin
                bus.mult_a <= a_sel_c;
                bus.mult_b <= b_sel_c;
                cnt        <= '0;
                owner      <= grant_idx_c;
                prio       <= ~grant_idx_c;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture_c) begin
                if (owner) bus.product1 <= bus.mult_c;
                else       bus.product0 <= bus.mult_c;
                bus.disp_product <= bus.mult_c;
                bus.disp_src     <= owner;
                bus.done         <= owner ? 2'b10 : 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: three instances cover INVERT_A=0/1 and
// WAIT_CYCLES=2/1, each with a behavioural external multiplier.
module tb_mult_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    mult_arbiter_if if0 ();
    mult_arbiter_if if1 ();
    mult_arbiter_if if2 ();

    assign if0.mult_c = 16'(if0.mult_a) * 16'(if0.mult_b);
    assign if1.mult_c = 16'(if1.mult_a) * 16'(if1.mult_b);
    assign if2.mult_c = 16'(if2.mult_a) * 16'(if2.mult_b);

    mult_arbiter #(.WAIT_CYCLES(2), .INVERT_A(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mult_arbiter #(.WAIT_CYCLES(2), .INVERT_A(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mult_arbiter #(.WAIT_CYCLES(1), .INVERT_A(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        if0.req = 2'b00;
        if1.req = 2'b00;
        if2.req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        if0.req = 2'b11; if0.a0 = 8'h55; if0.b0 = 8'h66; if0.a1 = 8'h77; if0.b1 = 8'h88;
        repeat (3) @(negedge clk);
        n_vec++; if (if0.done !== 2'b00)          begin n_bad++; $display("FAIL reset_done got %b exp 00", if0.done); end
        n_vec++; if (if0.busy !== 1'b0)           begin n_bad++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
        n_vec++; if (if0.product0 !== 16'h0)      begin n_bad++; $display("FAIL reset_product0 got %h exp 0000", if0.product0); end
        n_vec++; if (if0.product1 !== 16'h0)      begin n_bad++; $display("FAIL reset_product1 got %h exp 0000", if0.product1); end
        n_vec++; if (if0.mult_a !== 8'h0)         begin n_bad++; $display("FAIL reset_mult_a got %h exp 00", if0.mult_a); end
        n_vec++; if (if0.mult_b !== 8'h0)         begin n_bad++; $display("FAIL reset_mult_b got %h exp 00", if0.mult_b); end
        n_vec++; if (if0.disp_product !== 16'h0)  begin n_bad++; $display("FAIL reset_disp_product got %h exp 0000", if0.disp_product); end
        n_vec++; if (if0.disp_src !== 1'b0)       begin n_bad++; $display("FAIL reset_disp_src got %b exp 0", if0.disp_src); end
        n_vec++; if (if1.busy !== 1'b0)           begin n_bad++; $display("FAIL reset_busy_u1 got %b exp 0", if1.busy); end
        n_vec++; if (if2.busy !== 1'b0)           begin n_bad++; $display("FAIL reset_busy_u2 got %b exp 0", if2.busy); end
        if0.req = 2'b00; if0.a0 = 8'h0; if0.b0 = 8'h0; if0.a1 = 8'h0; if0.b1 = 8'h0;
        rst_n = 1'b1;
    endtask

    // Single request from requester 0, latency and result checked cycle by cycle
    task automatic test_single();
        logic [1:0] exp_done;
        if0.req = 2'b01; if0.a0 = 8'd12; if0.b0 = 8'd10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if0.req = 2'b00;
                n_vec++; if (if0.mult_a !== 8'd12) begin n_bad++; $display("FAIL single_mult_a got %h exp 0c", if0.mult_a); end
                n_vec++; if (if0.mult_b !== 8'd10) begin n_bad++; $display("FAIL single_mult_b got %h exp 0a", if0.mult_b); end
            end
            exp_done = (k == 3) ? 2'b01 : 2'b00;
            n_vec++; if (if0.done !== exp_done) begin n_bad++; $display("FAIL single_done k=%0d got %b exp %b", k, if0.done, exp_done); end
            n_vec++; if (if0.busy !== (k <= 3)) begin n_bad++; $display("FAIL single_busy k=%0d got %b exp %b", k, if0.busy, (k <= 3)); end
        end
        n_vec++; if (if0.product0 !== 16'h0078)     begin n_bad++; $display("FAIL single_product0 got %h exp 0078", if0.product0); end
        n_vec++; if (if0.product1 !== 16'h0000)     begin n_bad++; $display("FAIL single_product1 got %h exp 0000", if0.product1); end
        n_vec++; if (if0.disp_product !== 16'h0078) begin n_bad++; $display("FAIL single_disp_product got %h exp 0078", if0.disp_product); end
        n_vec++; if (if0.disp_src !== 1'b0)         begin n_bad++; $display("FAIL single_disp_src got %b exp 0", if0.disp_src); end
    endtask

    // Both requesting continuously: grants alternate starting with requester 0
    task automatic test_round_robin();
        logic [1:0] exp_done;
        apply_reset();
        if0.a0 = 8'd255; if0.b0 = 8'd255; if0.a1 = 8'd3; if0.b1 = 8'd5;
        if0.req = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_done = (k % 4 == 3) ? (((k / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_vec++; if (if0.done !== exp_done) begin n_bad++; $display("FAIL rr_done k=%0d got %b exp %b", k, if0.done, exp_done); end
            if (exp_done == 2'b01) begin
                n_vec++; if (if0.product0 !== 16'hFE01) begin n_bad++; $display("FAIL rr_product0 k=%0d got %h exp fe01", k, if0.product0); end
            end
            if (exp_done == 2'b10) begin
                n_vec++; if (if0.product1 !== 16'h000F) begin n_bad++; $display("FAIL rr_product1 k=%0d got %h exp 000f", k, if0.product1); end
                n_vec++; if (if0.disp_src !== 1'b1)     begin n_bad++; $display("FAIL rr_disp_src k=%0d got %b exp 1", k, if0.disp_src); end
            end
        end
        if0.req = 2'b00;
        repeat (3) @(negedge clk);
        n_vec++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle_busy got %b exp 0", if0.busy); end
    endtask

    // Reset in WAIT aborts the multiply; a later request runs normally
    task automatic test_reset_in_wait();
        logic [1:0] exp_done;
        apply_reset();
        if0.req = 2'b01; if0.a0 = 8'd7; if0.b0 = 8'd9;
        @(negedge clk);
        n_vec++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b exp 1", if0.busy); end
        if0.req = 2'b00;
        rst_n = 1'b0;
        #1;
        n_vec++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_in_reset got %b exp 0", if0.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_vec++; if (if0.done !== 2'b00) begin n_bad++; $display("FAIL abort_done k=%0d got %b exp 00", k, if0.done); end
        end
        n_vec++; if (if0.product0 !== 16'h0) begin n_bad++; $display("FAIL abort_product0 got %h exp 0000", if0.product0); end
        n_vec++; if (if0.product1 !== 16'h0) begin n_bad++; $display("FAIL abort_product1 got %h exp 0000", if0.product1); end
        if0.req = 2'b10; if0.a1 = 8'd6; if0.b1 = 8'd7;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) if0.req = 2'b00;
            exp_done = (k == 3) ? 2'b10 : 2'b00;
            n_vec++; if (if0.done !== exp_done) begin n_bad++; $display("FAIL abort_next_done k=%0d got %b exp %b", k, if0.done, exp_done); end
        end
        n_vec++; if (if0.product1 !== 16'h002A) begin n_bad++; $display("FAIL abort_next_product1 got %h exp 002a", if0.product1); end
        n_vec++; if (if0.product0 !== 16'h0000) begin n_bad++; $display("FAIL abort_next_product0 got %h exp 0000", if0.product0); end
    endtask

    // Operands changed right after the grant must not disturb the result
    task automatic test_operand_change();
        if0.req = 2'b01; if0.a0 = 8'd20; if0.b0 = 8'd30;
        @(negedge clk);
        if0.req = 2'b00; if0.a0 = 8'd1; if0.b0 = 8'd1;
        @(negedge clk);
        n_vec++; if (if0.mult_a !== 8'd20) begin n_bad++; $display("FAIL opchg_mult_a got %h exp 14", if0.mult_a); end
        @(negedge clk);
        n_vec++; if (if0.done !== 2'b01)            begin n_bad++; $display("FAIL opchg_done got %b exp 01", if0.done); end
        n_vec++; if (if0.product0 !== 16'h0258)     begin n_bad++; $display("FAIL opchg_product0 got %h exp 0258", if0.product0); end
        n_vec++; if (if0.product1 !== 16'h002A)     begin n_bad++; $display("FAIL opchg_product1_held got %h exp 002a", if0.product1); end
        n_vec++; if (if0.disp_product !== 16'h0258) begin n_bad++; $display("FAIL opchg_disp_product got %h exp 0258", if0.disp_product); end
    endtask

    // INVERT_A complements operand a; mult_a holds while idle
    task automatic test_invert();
        if1.req = 2'b10; if1.a1 = 8'hF3; if1.b1 = 8'h02; if1.a0 = 8'h00; if1.b0 = 8'h00;
        @(negedge clk);
        if1.req = 2'b00;
        n_vec++; if (if1.mult_a !== 8'h0C) begin n_bad++; $display("FAIL inv_mult_a got %h exp 0c", if1.mult_a); end
        n_vec++; if (if1.mult_b !== 8'h02) begin n_bad++; $display("FAIL inv_mult_b got %h exp 02", if1.mult_b); end
        repeat (2) @(negedge clk);
        n_vec++; if (if1.done !== 2'b10)        begin n_bad++; $display("FAIL inv_done got %b exp 10", if1.done); end
        n_vec++; if (if1.product1 !== 16'h0018) begin n_bad++; $display("FAIL inv_product1 got %h exp 0018", if1.product1); end
        n_vec++; if (if1.disp_src !== 1'b1)     begin n_bad++; $display("FAIL inv_disp_src got %b exp 1", if1.disp_src); end
        if1.a1 = 8'h00; if1.b1 = 8'hFF;
        repeat (3) @(negedge clk);
        n_vec++; if (if1.mult_a !== 8'h0C) begin n_bad++; $display("FAIL idle_hold_mult_a got %h exp 0c", if1.mult_a); end
        n_vec++; if (if1.mult_b !== 8'h02) begin n_bad++; $display("FAIL idle_hold_mult_b got %h exp 02", if1.mult_b); end
    endtask

    // WAIT_CYCLES=1: requester 0 raises and drops while requester 1 is served
    task automatic test_drop();
        logic [1:0] exp_done;
        if2.req = 2'b10; if2.a1 = 8'd4; if2.b1 = 8'd4; if2.a0 = 8'd9; if2.b0 = 8'd9;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_done = (k == 2) ? 2'b10 : 2'b00;
            n_vec++; if (if2.done !== exp_done) begin n_bad++; $display("FAIL drop_done k=%0d got %b exp %b", k, if2.done, exp_done); end
            if (k == 1) if2.req = 2'b01;
            if (k == 2) if2.req = 2'b00;
        end
        n_vec++; if (if2.product1 !== 16'h0010) begin n_bad++; $display("FAIL drop_product1 got %h exp 0010", if2.product1); end
        n_vec++; if (if2.product0 !== 16'h0000) begin n_bad++; $display("FAIL drop_product0 got %h exp 0000", if2.product0); end
        n_vec++; if (if2.busy !== 1'b0)         begin n_bad++; $display("FAIL drop_busy got %b exp 0", if2.busy); end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        if0.req = 2'b00; if0.a0 = 8'h0; if0.b0 = 8'h0; if0.a1 = 8'h0; if0.b1 = 8'h0;
        if1.req = 2'b00; if1.a0 = 8'h0; if1.b0 = 8'h0; if1.a1 = 8'h0; if1.b1 = 8'h0;
        if2.req = 2'b00; if2.a0 = 8'h0; if2.b0 = 8'h0; if2.a1 = 8'h0; if2.b1 = 8'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_reset_in_wait();
        test_operand_change();
        test_invert();
        test_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WAIT_CYCLES, default 2: number of cycles the shared multiplier settles before its product is captured. Legal range 1..15.
REQ-003 Parameter INVERT_A, default 1: when 1, operand a is bitwise complemented before it reaches the multiplier, to suit active-low board switches.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port req, input, 2: req[k] high means requester k wants a multiply.
REQ-007 Ports a0, b0, a1, b1, inputs, 8 each: operands of requester 0 and requester 1.
REQ-008 Port done, output, 2: done[k] is a one-cycle pulse meaning product_k has been updated.
REQ-009 Ports product0, product1, outputs, 16 each: last result per requester.
REQ-010 Ports mult_a, mult_b, outputs, 8 each: registered operands driven to the external combinational 8x8 multiplier.
REQ-011 Port mult_c, input, 16: product returned by the external multiplier.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port disp_product, output, 16: most recent product from either requester, for the 4-digit display.
REQ-014 Port disp_src, output, 1: index of the requester that produced disp_product.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-016 In IDLE, when any req bit is high at an edge, the block SHALL grant one requester and go to WAIT. At the same edge it SHALL latch that requester's operands into mult_a/mult_b, with INVERT_A applied to a, and clear the counter cnt to 0.
REQ-017 Arbitration SHALL be round-robin. When both req bits are high, the requester not granted last time wins. After reset, the pointer SHALL favour requester 0.
REQ-018 In WAIT, cnt SHALL increment by 1 each cycle.
REQ-019 At the edge where cnt==WAIT_CYCLES-1, the block SHALL capture mult_c into product_k, disp_product and disp_src, and go to DONE.
REQ-020 In DONE, done[k] SHALL be high for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-021 Latency: if a request is sampled at edge E0, done[k] SHALL be high in the cycle after edge E0+WAIT_CYCLES.
REQ-022 Operand changes on a0/b0/a1/b1 after the grant edge SHALL NOT affect the in-flight multiply.
REQ-023 req SHALL be sampled only in IDLE. If req[k] is still high at the edge leaving DONE, it is a new request and SHALL be arbitrated in the following IDLE cycle.
REQ-024 A req that drops before it is granted SHALL be ignored and SHALL produce no done pulse.
REQ-025 product_k SHALL hold its value until the next done[k]. The other requester's product SHALL NOT change.
REQ-026 At most one done bit SHALL be high in any cycle.
REQ-027 mult_a and mult_b SHALL hold their values in IDLE.
REQ-028 No arithmetic is performed inside the block; product width is fixed at 16 bits and no truncation occurs.

Reset
REQ-029 While rst_n is low, all of the following SHALL be 0: state (IDLE), cnt, done, busy, product0, product1, mult_a, mult_b, disp_product, disp_src. The round-robin pointer SHALL reset to favour requester 0.
REQ-030 Reset asserted during WAIT or DONE SHALL abort the operation: no done pulse, and no product register update.
REQ-031 After rst_n rises, the first edge SHALL be treated as IDLE.

Verification
REQ-032 INVERT_A=0, WAIT_CYCLES=2: req=01 with a0=12, b0=10 held one cycle -> done=01 in the cycle after edge E0+2, product0=0x0078, disp_src=0, product1 stays 0.
REQ-033 INVERT_A=0: req=11 held continuously with a0=255, b0=255, a1=3, b1=5 -> first done=01 with product0=0xFE01, next done=10 with product1=0x000F, alternating thereafter.
REQ-034 INVERT_A=1: a1=0xF3, b1=0x02 -> mult_a=0x0C, product1=0x0018.
REQ-035 rst_n pulsed low during WAIT -> no done pulse, product0 and product1 = 0, busy=0, next req=10 granted normally.
REQ-036 WAIT_CYCLES=1, req[0] dropped before the grant edge while busy with requester 1 -> only done[1] pulses; requester 0 is never served.
REQ-037 Operands changed on the cycle after the grant -> product matches the operands latched at the grant edge.
